// File: rtl/al422_bam_pkg.sv
// -----------------------------------------------------------------------------
// al422_bam_pkg
// Shared types and helpers for the BAM row scheduler:
//   bam_sched_state_t  - scheduler FSM state encoding
//   BAM_MIN_DURATION   - smallest OE pulse length ever issued
//   bam_plane_duration - plane-weighted, brightness-scaled OE pulse length
// -----------------------------------------------------------------------------
package al422_bam_pkg;

   typedef enum logic [2:0] {
      IDLE,
      LOAD_REQ,
      LOAD_SETTLE,
      LOAD_WAIT,
      OE_WAIT,
      LATCH,
      FIRE,
      DRAIN
   } bam_sched_state_t;

   // A zero duration would make the OE processor run a full 256-tick pulse,
   // so the scheduler never issues anything shorter than this.
   localparam logic [7:0] BAM_MIN_DURATION = 8'd1;

   // duration = (brightness * 2^plane) >> (bitplanes-1), floored at 1.
   // With plane <= bitplanes-1 the shifted result always fits in 8 bits.
   function automatic logic [7:0] bam_plane_duration(
      input logic [7:0]  brightness,
      input logic [2:0]  plane,
      input int unsigned bitplanes
   );
      logic [15:0] p;
      logic [7:0]  d;
      p = {8'h00, brightness} << plane;
      d = 8'(p >> (bitplanes - 1));
      return (d == 8'd0) ? BAM_MIN_DURATION : d;
   endfunction

endpackage

// File: rtl/al422_bam_index_counter.sv
// -----------------------------------------------------------------------------
// al422_bam_index_counter
// Row x bit-plane load index. Plane counts fastest; row steps when the plane
// wraps; the whole index wraps to (0,0) after (ROWS-1, BITPLANES-1).
// Ports:
//   in_clk, in_rst - clock, synchronous active-high reset
//   clear          - force index to (0,0)
//   advance        - step to the next index
//   row, plane     - current index (registered)
//   frame_wrap     - high while the index is the last of a frame
// -----------------------------------------------------------------------------
module al422_bam_index_counter
   import al422_bam_pkg::*;
#(
   parameter int ROWS      = 16,
   parameter int BITPLANES = 8,
   parameter int ROW_W     = $clog2(ROWS),
   parameter int PLANE_W   = (BITPLANES > 1) ? $clog2(BITPLANES) : 1
) (
   input  logic               in_clk,
   input  logic               in_rst,
   input  logic               clear,
   input  logic               advance,
   output logic [ROW_W-1:0]   row,
   output logic [PLANE_W-1:0] plane,
   output logic               frame_wrap
);

   localparam logic [ROW_W-1:0]   ROW_LAST   = ROW_W'(ROWS - 1);
   localparam logic [PLANE_W-1:0] PLANE_LAST = PLANE_W'(BITPLANES - 1);

   logic [ROW_W-1:0]   row_reg;
   logic [PLANE_W-1:0] plane_reg;
   logic               row_last;
   logic               plane_last;

   assign row_last   = (row_reg == ROW_LAST);
   assign plane_last = (plane_reg == PLANE_LAST);
   assign frame_wrap = row_last && plane_last;
   assign row        = row_reg;
   assign plane      = plane_reg;

   always_ff @(posedge in_clk) begin
      if (in_rst || clear) begin
         row_reg   <= '0;
         plane_reg <= '0;
      end else if (advance) begin
         if (plane_last) begin
            plane_reg <= '0;
            row_reg   <= row_last ? '0 : row_reg + ROW_W'(1);
         end else begin
            plane_reg <= plane_reg + PLANE_W'(1);
         end
      end
   end

endmodule

// File: rtl/al422_bam_row_scheduler.sv
// -----------------------------------------------------------------------------
// al422_bam_row_scheduler
// Sequences one BAM refresh: for every row x plane index it requests the
// shift loader, waits for the loader and the previous OE pulse, latches and
// switches the row, then fires an OE pulse of plane-weighted length. The next
// load is requested right after the fire so loading overlaps the OE pulse.
// Ports:
//   in_clk, in_rst         - clock, synchronous active-high reset
//   enable                 - run scanning while high
//   brightness             - global brightness, sampled when the pulse fires
//   load_start/row/plane   - loader request and index to load
//   load_busy              - loader busy
//   latch, row_addr        - LAT pulse and displayed row address
//   oe_start, oe_duration  - OE processor start and pulse length
//   oe_busy                - OE processor busy
//   frame_done             - pulse with the fire of the last index of a frame
// -----------------------------------------------------------------------------
module al422_bam_row_scheduler
   import al422_bam_pkg::*;
#(
   parameter int ROWS      = 16,
   parameter int BITPLANES = 8,
   parameter int ROW_W     = $clog2(ROWS),
   parameter int PLANE_W   = (BITPLANES > 1) ? $clog2(BITPLANES) : 1
) (
   input  logic               in_clk,
   input  logic               in_rst,
   input  logic               enable,
   input  logic [7:0]         brightness,
   output logic               load_start,
   output logic [ROW_W-1:0]   load_row,
   output logic [PLANE_W-1:0] load_plane,
   input  logic               load_busy,
   output logic               latch,
   output logic [ROW_W-1:0]   row_addr,
   output logic               oe_start,
   output logic [7:0]         oe_duration,
   input  logic               oe_busy,
   output logic               frame_done
);

   bam_sched_state_t   state_reg;
   logic               load_start_reg;
   logic               latch_reg;
   logic               oe_start_reg;
   logic               frame_done_reg;
   logic [ROW_W-1:0]   row_addr_reg;
   logic [PLANE_W-1:0] display_plane_reg;
   logic [7:0]         oe_duration_reg;
   // High the cycle after FIRE: the OE processor has not yet raised busy.
   logic               oe_guard_reg;
   logic               oe_ready;
   logic               frame_wrap;

   assign oe_ready = !oe_busy && !oe_guard_reg;

   al422_bam_index_counter #(
      .ROWS      (ROWS),
      .BITPLANES (BITPLANES),
      .ROW_W     (ROW_W),
      .PLANE_W   (PLANE_W)
   ) u_index (
      .in_clk     (in_clk),
      .in_rst     (in_rst),
      .clear      (state_reg == IDLE),
      .advance    (state_reg == FIRE),
      .row        (load_row),
      .plane      (load_plane),
      .frame_wrap (frame_wrap)
   );

   always_ff @(posedge in_clk) begin
      if (in_rst) begin
         state_reg         <= IDLE;
         load_start_reg    <= 1'b0;
         latch_reg         <= 1'b0;
         oe_start_reg      <= 1'b0;
         frame_done_reg    <= 1'b0;
         row_addr_reg      <= '0;
         display_plane_reg <= '0;
         oe_duration_reg   <= BAM_MIN_DURATION;
         oe_guard_reg      <= 1'b0;
      end else begin
         load_start_reg <= 1'b0;
         latch_reg      <= 1'b0;
         oe_start_reg   <= 1'b0;
         frame_done_reg <= 1'b0;
         oe_guard_reg   <= (state_reg == FIRE);

         // Pulse outputs are registered on entry, so each one is high exactly
         // while the FSM sits in the state it belongs to.
         case (state_reg)
            IDLE: begin
               if (enable) begin
                  state_reg      <= LOAD_REQ;
                  load_start_reg <= 1'b1;
               end
            end
            LOAD_REQ:    state_reg <= LOAD_SETTLE;
            // Loader raises busy one cycle late; do not look at it yet.
            LOAD_SETTLE: state_reg <= LOAD_WAIT;
            // Loader done is honoured first; if the OE side is already free
            // in the same cycle the latch follows directly.
            LOAD_WAIT: begin
               if (!load_busy) begin
                  if (oe_ready) begin
                     state_reg         <= LATCH;
                     latch_reg         <= 1'b1;
                     row_addr_reg      <= load_row;
                     display_plane_reg <= load_plane;
                  end else begin
                     state_reg <= OE_WAIT;
                  end
               end
            end
            OE_WAIT: begin
               if (oe_ready) begin
                  state_reg         <= LATCH;
                  latch_reg         <= 1'b1;
                  row_addr_reg      <= load_row;
                  display_plane_reg <= load_plane;
               end
            end
            LATCH: begin
               state_reg       <= FIRE;
               oe_start_reg    <= 1'b1;
               oe_duration_reg <= bam_plane_duration(brightness, 3'(display_plane_reg),
                                                     BITPLANES);
               frame_done_reg  <= frame_wrap;
            end
            FIRE: begin
               if (enable) begin
                  state_reg      <= LOAD_REQ;
                  load_start_reg <= 1'b1;
               end else begin
                  state_reg <= DRAIN;
               end
            end
            DRAIN: begin
               if (oe_ready) state_reg <= IDLE;
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

   assign load_start  = load_start_reg;
   assign latch       = latch_reg;
   assign row_addr    = row_addr_reg;
   assign oe_start    = oe_start_reg;
   assign oe_duration = oe_duration_reg;
   assign frame_done  = frame_done_reg;

endmodule

// File: tb/tb_al422_bam_row_scheduler.sv
// -----------------------------------------------------------------------------
// tb_al422_bam_row_scheduler
// Scoreboard bench: each phase pushes the fires it expects (row, duration,
// frame_done); a monitor pops one entry per oe_start and compares. Loader and
// OE processor are modelled as busy counters with programmable length.
// -----------------------------------------------------------------------------
module tb_al422_bam_row_scheduler;
   import al422_bam_pkg::*;

   localparam int ROWS      = 4;
   localparam int BITPLANES = 8;
   localparam int ROW_W     = 2;
   localparam int PLANE_W   = 3;

   logic               in_clk = 1'b0;
   logic               in_rst;
   logic               enable;
   logic [7:0]         brightness;
   logic               load_start;
   logic [ROW_W-1:0]   load_row;
   logic [PLANE_W-1:0] load_plane;
   logic               load_busy;
   logic               latch;
   logic [ROW_W-1:0]   row_addr;
   logic               oe_start;
   logic [7:0]         oe_duration;
   logic               oe_busy;
   logic               frame_done;

   al422_bam_row_scheduler #(
      .ROWS      (ROWS),
      .BITPLANES (BITPLANES),
      .ROW_W     (ROW_W),
      .PLANE_W   (PLANE_W)
   ) dut (
      .in_clk      (in_clk),
      .in_rst      (in_rst),
      .enable      (enable),
      .brightness  (brightness),
      .load_start  (load_start),
      .load_row    (load_row),
      .load_plane  (load_plane),
      .load_busy   (load_busy),
      .latch       (latch),
      .row_addr    (row_addr),
      .oe_start    (oe_start),
      .oe_duration (oe_duration),
      .oe_busy     (oe_busy),
      .frame_done  (frame_done)
   );

   always #5 in_clk = ~in_clk;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   always @(posedge in_clk) cyc <= cyc + 1;

   // ---------------- loader / OE busy models ----------------
   int load_lat = 0;
   int oe_lat   = 0;
   int lcnt     = 0;
   int ocnt     = 0;

   always @(posedge in_clk) begin
      if (in_rst) begin
         lcnt <= 0;
         ocnt <= 0;
      end else begin
         if (load_start && load_lat != 0) lcnt <= load_lat;
         else if (lcnt != 0)              lcnt <= lcnt - 1;
         if (oe_start && oe_lat != 0)     ocnt <= oe_lat;
         else if (ocnt != 0)              ocnt <= ocnt - 1;
      end
   end

   assign load_busy = (lcnt != 0);
   assign oe_busy   = (ocnt != 0);

   // ---------------- checking ----------------
   task automatic check(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
      end
   endtask

   typedef struct {
      int row;
      int dur;
      int fd;
   } exp_t;

   exp_t exp_q[$];
   int   tbl255 [8] = '{1, 3, 7, 15, 31, 63, 127, 255};
   int   tbl128 [8] = '{1, 2, 4, 8, 16, 32, 64, 128};
   bit   overlap_seen = 1'b0;
   int   fd_cnt = 0;

   task automatic push_exp(input int row, input int dur, input int fd);
      exp_t e;
      e.row = row;
      e.dur = dur;
      e.fd  = fd;
      exp_q.push_back(e);
   endtask

   // Monitor: one scoreboard pop per fire, plus latch/OE ordering rules.
   initial begin : monitor
      exp_t e;
      logic latch_d;
      logic oe_start_d;
      latch_d    = 1'b0;
      oe_start_d = 1'b0;
      forever begin
         @(negedge in_clk);
         if (!in_rst) begin
            if (oe_start) begin
               if (exp_q.size() == 0) begin
                  check("unexpected_fire", 1, 0);
               end else begin
                  e = exp_q.pop_front();
                  check("oe_duration", int'(oe_duration), e.dur);
                  check("row_addr", int'(row_addr), e.row);
                  check("frame_done", int'(frame_done), e.fd);
                  check("latch_before_fire", int'(latch_d), 1);
                  $display("fire row=%0d dur=%0d frame_done=%0d cycle=%0d",
                           row_addr, oe_duration, frame_done, cyc);
               end
            end else if (frame_done) begin
               check("frame_done_without_fire", 1, 0);
            end
            if (latch) begin
               check("latch_while_oe_busy", int'(oe_busy), 0);
               check("latch_after_fire", int'(oe_start_d), 0);
            end
            if (load_start && oe_busy) overlap_seen = 1'b1;
            if (frame_done) fd_cnt++;
         end
         latch_d    = latch;
         oe_start_d = oe_start;
      end
   end

   // ---------------- stimulus helpers ----------------
   int ls_cnt, lat_cnt, oe_cnt;
   int t_ls0, t_ls1, t_lat0, t_oe0, t_en;

   task automatic clear_counts();
      ls_cnt  = 0;
      lat_cnt = 0;
      oe_cnt  = 0;
      t_ls0   = -1;
      t_ls1   = -1;
      t_lat0  = -1;
      t_oe0   = -1;
   endtask

   task automatic step();
      @(negedge in_clk);
      if (load_start) begin
         if (ls_cnt == 0)      t_ls0 = cyc;
         else if (ls_cnt == 1) t_ls1 = cyc;
         ls_cnt++;
      end
      if (latch) begin
         if (lat_cnt == 0) t_lat0 = cyc;
         lat_cnt++;
      end
      if (oe_start) begin
         if (oe_cnt == 0) t_oe0 = cyc;
         oe_cnt++;
      end
   endtask

   // Run until n fires in total were seen; optionally drop enable in the
   // FIRE cycle of the last one so exactly n indices are displayed.
   task automatic run_fires(input int n, input int budget, input bit drop);
      int k = 0;
      while (oe_cnt < n && k < budget) begin
         step();
         k++;
      end
      if (drop) enable = 1'b0;
      check("fire_count", oe_cnt, n);
   endtask

   // ---------------- main sequence ----------------
   initial begin : main
      int k;
      int fd0;
      in_rst     = 1'b1;
      enable     = 1'b0;
      brightness = 8'd0;
      clear_counts();
      repeat (3) @(negedge in_clk);
      in_rst = 1'b0;

      // Reset state
      check("rst_state_idle", int'(dut.state_reg == IDLE), 1);
      check("rst_pulses", int'({load_start, latch, oe_start, frame_done}), 0);
      check("rst_row_addr", int'(row_addr), 0);
      check("rst_load_index", int'({load_row, load_plane}), 0);
      check("rst_oe_duration", int'(oe_duration), 1);
      repeat (4) step();
      check("idle_no_load", ls_cnt, 0);

      // Fast path, brightness 255: durations 1..255 on row 0, timing
      brightness = 8'd255;
      for (int p = 0; p < 8; p++) push_exp(0, tbl255[p], 0);
      clear_counts();
      t_en   = cyc;
      enable = 1'b1;
      run_fires(8, 200, 1'b1);
      check("enable_to_load_start", t_ls0 - t_en, 1);
      check("load_start_to_latch", t_lat0 - t_ls0, 3);
      check("load_start_to_oe_start", t_oe0 - t_ls0, 4);
      check("load_start_to_next_load", t_ls1 - t_ls0, 5);
      repeat (20) step();

      // Brightness 0: every plane still gets duration 1
      brightness = 8'd0;
      for (int p = 0; p < 8; p++) push_exp(0, 1, 0);
      clear_counts();
      enable = 1'b1;
      run_fires(8, 200, 1'b1);
      repeat (20) step();

      // Brightness 128: 1,2,4,...,128
      brightness = 8'd128;
      for (int p = 0; p < 8; p++) push_exp(0, tbl128[p], 0);
      clear_counts();
      enable = 1'b1;
      run_fires(8, 200, 1'b1);
      repeat (20) step();

      // Full frame plus one row: row sequence and single frame_done
      brightness = 8'd255;
      for (int i = 0; i < 40; i++) push_exp((i / 8) % 4, tbl255[i % 8], (i == 31) ? 1 : 0);
      fd0 = fd_cnt;
      clear_counts();
      enable = 1'b1;
      run_fires(40, 400, 1'b1);
      check("frame_done_per_frame", fd_cnt - fd0, 1);
      repeat (20) step();

      // Slow loader and OE: overlap, then reset while waiting on OE
      load_lat     = 10;
      oe_lat       = 40;
      overlap_seen = 1'b0;
      for (int i = 0; i < 9; i++) push_exp(i / 8, tbl255[i % 8], 0);
      clear_counts();
      enable = 1'b1;
      run_fires(9, 1000, 1'b0);
      check("load_overlaps_oe", int'(overlap_seen), 1);
      k = 0;
      while (dut.state_reg != OE_WAIT && k < 100) begin
         step();
         k++;
      end
      check("reach_oe_wait", int'(dut.state_reg == OE_WAIT), 1);
      in_rst = 1'b1;
      @(negedge in_clk);
      check("midrst_state_idle", int'(dut.state_reg == IDLE), 1);
      check("midrst_row_addr", int'(row_addr), 0);
      check("midrst_pulses", int'({load_start, latch, oe_start, frame_done}), 0);
      check("midrst_load_index", int'({load_row, load_plane}), 0);
      in_rst = 1'b0;
      enable = 1'b0;
      repeat (5) step();

      // Enable dropped in LOAD_WAIT of the 4th index
      oe_lat   = 0;
      load_lat = 10;
      for (int p = 0; p < 4; p++) push_exp(0, tbl255[p], 0);
      clear_counts();
      enable = 1'b1;
      k = 0;
      while (ls_cnt < 4 && k < 300) begin
         step();
         k++;
      end
      check("fourth_load_start", ls_cnt, 4);
      step();
      step();
      check("drop_in_load_wait", int'(dut.state_reg == LOAD_WAIT), 1);
      enable = 1'b0;
      repeat (100) step();
      check("drop_fire_count", oe_cnt, 4);
      check("drop_no_new_load", ls_cnt, 4);
      check("drop_latch_count", lat_cnt, 4);

      // Re-enable restarts at (0,0)
      push_exp(0, 1, 0);
      enable = 1'b1;
      k = 0;
      while (ls_cnt < 5 && k < 20) begin
         step();
         k++;
      end
      check("restart_load_start", ls_cnt, 5);
      check("restart_load_row", int'(load_row), 0);
      check("restart_load_plane", int'(load_plane), 0);
      run_fires(5, 100, 1'b1);
      repeat (20) step();

      check("scoreboard_empty", exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin : watchdog
      #400000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "simulation time limit");
   end

endmodule
